// File: rtl/inst_fetch_resp_pkg.sv
// Shared definitions for the instruction-fetch responder: state encodings,
// bus widths and the byte-lane helper used to assemble a word from bytes.
package inst_fetch_resp_pkg;

  localparam int InstAddrBus = 32;
  localparam int RegBus      = 32;
  localparam int ByteWidth   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  // Return word with byte lane 'lane' replaced by b (lane 0 = bits 7:0).
  function automatic logic [RegBus-1:0] put_byte(
    input logic [RegBus-1:0]    word,
    input logic [1:0]           lane,
    input logic [ByteWidth-1:0] b
  );
    logic [RegBus-1:0] r;
    r = word;
    r[lane*ByteWidth +: ByteWidth] = b;
    return r;
  endfunction

endpackage

// File: rtl/inst_fetch_resp_if.sv
// Fetch port (core side) plus byte-memory port of the fetch responder.
// The slave modport is the responder's view; master is the core/memory side.
interface inst_fetch_resp_if
  import inst_fetch_resp_pkg::*;
#(
  parameter int MEM_AW = 17
) ();

  logic                   rom_ce_i;
  logic [InstAddrBus-1:0] rom_addr_i;
  logic [RegBus-1:0]      rom_data_o;
  logic                   rom_ready_o;
  logic [MEM_AW-1:0]      mem_a_o;
  logic                   mem_rd_o;
  logic [ByteWidth-1:0]   mem_din_i;

  modport slave (
    input  rom_ce_i,
    input  rom_addr_i,
    output rom_data_o,
    output rom_ready_o,
    output mem_a_o,
    output mem_rd_o,
    input  mem_din_i
  );

  modport master (
    output rom_ce_i,
    output rom_addr_i,
    input  rom_data_o,
    input  rom_ready_o,
    input  mem_a_o,
    input  mem_rd_o,
    output mem_din_i
  );

endinterface

// File: rtl/inst_fetch_resp_rom_hit_cache.sv
// One-entry last-word cache (valid, word-address tag, data) for the fetch
// responder; only instantiated when ROM_HIT_CACHE_EN is defined.
module inst_fetch_resp_rom_hit_cache
  import inst_fetch_resp_pkg::*;
#(
  parameter int WAW = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WAW-1:0]    lookup_word,
  output logic              hit,
  output logic [RegBus-1:0] hit_data,
  input  logic              fill_en,
  input  logic [WAW-1:0]    fill_word,
  input  logic [RegBus-1:0] fill_data
);

  logic              valid_reg;
  logic [WAW-1:0]    tag_reg;
  logic [RegBus-1:0] data_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      tag_reg   <= '0;
      data_reg  <= '0;
    end else if (fill_en) begin
      valid_reg <= 1'b1;
      tag_reg   <= fill_word;
      data_reg  <= fill_data;
    end
  end

  assign hit      = valid_reg && (tag_reg == lookup_word);
  assign hit_data = data_reg;

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: builds a little-endian 32-bit word from four
// byte reads. Optional last-word cache enabled by defining ROM_HIT_CACHE_EN.
module inst_fetch_resp
  import inst_fetch_resp_pkg::*;
#(
  parameter int MEM_AW = 17
) (
  input  logic             clk,
  input  logic             rst,
  inst_fetch_resp_if.slave bus
);

  localparam int WAW = MEM_AW - 2;

  fetch_state_t      state_reg;
  logic [1:0]        cnt_reg;
  logic [WAW-1:0]    base_reg;
  logic [RegBus-1:0] asm_reg;
  logic [RegBus-1:0] data_reg;
  logic              ready_reg;
  logic              rd_reg;
  logic              hit_pend_reg;
  logic [MEM_AW-1:0] a_reg;

  logic [WAW-1:0]    req_word;
  logic [MEM_AW-1:0] next_addr;
  logic [RegBus-1:0] asm_next;
  logic              restart;
  logic              accept;
  logic              complete;
  logic              cache_hit;
  logic [RegBus-1:0] cache_data;
  logic              unused_addr_bits;

  assign req_word         = bus.rom_addr_i[MEM_AW-1:2];
  assign unused_addr_bits = ^{bus.rom_addr_i[InstAddrBus-1:MEM_AW], bus.rom_addr_i[1:0]};

  // Address wraps naturally at MEM_AW bits.
  assign next_addr = {base_reg, 2'b00} + MEM_AW'(cnt_reg) + MEM_AW'(1);
  assign asm_next  = put_byte(asm_reg, cnt_reg, bus.mem_din_i);

  assign restart  = (state_reg == READ) && bus.rom_ce_i && (req_word != base_reg);
  assign accept   = (((state_reg == IDLE) || (state_reg == DONE)) && bus.rom_ce_i) || restart;
  assign complete = (state_reg == READ) && bus.rom_ce_i && !restart && !hit_pend_reg
                    && (cnt_reg == 2'd3);

`ifdef ROM_HIT_CACHE_EN
  inst_fetch_resp_rom_hit_cache #(
    .WAW (WAW)
  ) u_cache (
    .clk         (clk),
    .rst         (rst),
    .lookup_word (req_word),
    .hit         (cache_hit),
    .hit_data    (cache_data),
    .fill_en     (complete),
    .fill_word   (base_reg),
    .fill_data   (asm_next)
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      cnt_reg      <= 2'd0;
      base_reg     <= '0;
      asm_reg      <= '0;
      data_reg     <= '0;
      ready_reg    <= 1'b0;
      rd_reg       <= 1'b0;
      hit_pend_reg <= 1'b0;
      a_reg        <= '0;
    end else begin
      ready_reg <= 1'b0;
      if (accept) begin
        // A hit skips memory and completes on the following edge.
        state_reg    <= READ;
        base_reg     <= req_word;
        cnt_reg      <= 2'd0;
        hit_pend_reg <= cache_hit;
        rd_reg       <= !cache_hit;
        if (!cache_hit) begin
          a_reg <= {req_word, 2'b00};
        end
      end else begin
        case (state_reg)
          IDLE, DONE: begin
            state_reg <= IDLE;
            rd_reg    <= 1'b0;
          end
          READ: begin
            if (!bus.rom_ce_i) begin
              state_reg    <= IDLE;
              rd_reg       <= 1'b0;
              hit_pend_reg <= 1'b0;
            end else if (hit_pend_reg) begin
              data_reg     <= cache_data;
              ready_reg    <= 1'b1;
              hit_pend_reg <= 1'b0;
              state_reg    <= DONE;
            end else begin
              a_reg   <= next_addr;
              rd_reg  <= (cnt_reg != 2'd3);
              asm_reg <= asm_next;
              cnt_reg <= cnt_reg + 2'd1;
              if (complete) begin
                data_reg  <= asm_next;
                ready_reg <= 1'b1;
                state_reg <= DONE;
              end
            end
          end
          default: begin
            state_reg <= IDLE;
            rd_reg    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rom_data_o  = data_reg;
  assign bus.rom_ready_o = ready_reg;
  assign bus.mem_a_o     = a_reg;
  assign bus.mem_rd_o    = rd_reg;

endmodule

// File: tb/tb_inst_fetch_resp.sv
// Directed bench for inst_fetch_resp: table of aligned/unaligned fetches plus
// abort, restart, back-to-back and mid-fetch reset sequences.
module tb_inst_fetch_resp;
  import inst_fetch_resp_pkg::*;

  localparam int AW = 17;
`ifdef ROM_HIT_CACHE_EN
  localparam int HitGap = 2;
  localparam bit HitRd  = 1'b0;
`else
  localparam int HitGap = 5;
  localparam bit HitRd  = 1'b1;
`endif

  typedef struct {
    logic [31:0]   addr;
    logic [AW-1:0] base;
    logic [31:0]   word;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic [7:0] mem [0:(1<<AW)-1];

  inst_fetch_resp_if #(.MEM_AW(AW)) bus ();

  inst_fetch_resp #(.MEM_AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory: the byte sampled at an edge is the one addressed during the preceding cycle.
  assign bus.mem_din_i = mem[bus.mem_a_o];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_fetch(input logic [31:0] addr, input logic [AW-1:0] base,
                           input logic [31:0] word);
    logic [AW-1:0] a;
    @(negedge clk);
    bus.rom_ce_i   = 1'b1;
    bus.rom_addr_i = addr;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      a = base + AW'(k);
      check("mem_a", 32'(bus.mem_a_o), 32'(a));
      check("mem_rd", 32'(bus.mem_rd_o), 32'd1);
      check("ready_early", 32'(bus.rom_ready_o), 32'd0);
    end
    @(negedge clk);
    check("ready", 32'(bus.rom_ready_o), 32'd1);
    check("data", bus.rom_data_o, word);
    check("mem_rd_done", 32'(bus.mem_rd_o), 32'd0);
    bus.rom_ce_i = 1'b0;
    @(negedge clk);
    check("ready_pulse", 32'(bus.rom_ready_o), 32'd0);
    $display("fetch addr=%08h base=%05h data=%08h", addr, base, bus.rom_data_o);
  endtask

  task automatic wait_ready(input int bound, output int ready_cyc, output bit saw_rd);
    ready_cyc = -1;
    saw_rd    = 1'b0;
    for (int c = 0; c < bound; c++) begin
      @(negedge clk);
      if (bus.mem_rd_o) saw_rd = 1'b1;
      if (bus.rom_ready_o) begin
        ready_cyc = cyc;
        break;
      end
    end
    n_checks++;
    if (ready_cyc < 0) begin
      n_fail++;
      $display("FAIL ready_timeout: got no ready, expected ready within %0d cycles", bound);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    int   t0, t1, t2, t3;
    int   pulses, ready_at;
    bit   rd0, rd1, rd2;

    vecs[0] = '{32'h0000_0000, 17'h00000, 32'h0010_0513};
    vecs[1] = '{32'h0000_0106, 17'h00104, 32'hDEAD_BEEF};
    vecs[2] = '{32'h0001_FFFC, 17'h1FFFC, 32'h1234_5678};
    vecs[3] = '{32'h0002_000C, 17'h0000C, 32'h0040_0693};
    vecs[4] = '{32'hFFFE_0005, 17'h00004, 32'h0020_0593};

    rst            = 1'b0;
    bus.rom_ce_i   = 1'b0;
    bus.rom_addr_i = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'hA5;
    mem[17'h00000] = 8'h13; mem[17'h00001] = 8'h05; mem[17'h00002] = 8'h10; mem[17'h00003] = 8'h00;
    mem[17'h00004] = 8'h93; mem[17'h00005] = 8'h05; mem[17'h00006] = 8'h20; mem[17'h00007] = 8'h00;
    mem[17'h00008] = 8'h13; mem[17'h00009] = 8'h06; mem[17'h0000A] = 8'h30; mem[17'h0000B] = 8'h00;
    mem[17'h0000C] = 8'h93; mem[17'h0000D] = 8'h06; mem[17'h0000E] = 8'h40; mem[17'h0000F] = 8'h00;
    mem[17'h00104] = 8'hEF; mem[17'h00105] = 8'hBE; mem[17'h00106] = 8'hAD; mem[17'h00107] = 8'hDE;
    mem[17'h1FFFC] = 8'h78; mem[17'h1FFFD] = 8'h56; mem[17'h1FFFE] = 8'h34; mem[17'h1FFFF] = 8'h12;

    repeat (2) @(negedge clk);
    check("rst_data", bus.rom_data_o, 32'h0);
    check("rst_ready", 32'(bus.rom_ready_o), 32'd0);
    check("rst_mem_a", 32'(bus.mem_a_o), 32'd0);
    check("rst_mem_rd", 32'(bus.mem_rd_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_mem_rd", 32'(bus.mem_rd_o), 32'd0);

    for (int v = 0; v < 5; v++) begin
      run_fetch(vecs[v].addr, vecs[v].base, vecs[v].word);
    end

    // Abort at cnt=1: no ready, data keeps the previous word.
    @(negedge clk);
    bus.rom_ce_i   = 1'b1;
    bus.rom_addr_i = 32'h8;
    repeat (2) @(negedge clk);
    bus.rom_ce_i = 1'b0;
    @(negedge clk);
    check("abort_mem_rd", 32'(bus.mem_rd_o), 32'd0);
    pulses = 0;
    for (int c = 0; c < 5; c++) begin
      if (bus.rom_ready_o) pulses++;
      @(negedge clk);
    end
    check("abort_pulses", 32'(pulses), 32'd0);
    check("abort_data", bus.rom_data_o, 32'h0020_0593);
    $display("abort addr=00000008 data=%08h pulses=%0d", bus.rom_data_o, pulses);

    // Restart 0x8 -> 0xC at cnt=2.
    bus.rom_ce_i   = 1'b1;
    bus.rom_addr_i = 32'h8;
    repeat (3) @(negedge clk);
    bus.rom_addr_i = 32'hC;
    @(negedge clk);
    check("restart_mem_a", 32'(bus.mem_a_o), 32'hC);
    check("restart_mem_rd", 32'(bus.mem_rd_o), 32'd1);
    pulses   = 0;
    ready_at = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus.rom_ready_o) begin
        pulses++;
        if (ready_at < 0) ready_at = c;
        check("restart_data", bus.rom_data_o, 32'h0040_0693);
        bus.rom_ce_i = 1'b0;
      end
    end
    check("restart_pulses", 32'(pulses), 32'd1);
    check("restart_latency", 32'(ready_at), 32'd4);
    $display("restart addr=0000000c data=%08h latency=%0d", bus.rom_data_o, ready_at);

    // Back-to-back 0x0 then 0x4, then a repeat of 0x4.
    @(negedge clk);
    bus.rom_ce_i   = 1'b1;
    bus.rom_addr_i = 32'h0;
    t0 = cyc;
    wait_ready(10, t1, rd0);
    check("b2b_first_latency", 32'(t1 - t0), 32'd5);
    check("b2b_first_data", bus.rom_data_o, 32'h0010_0513);
    bus.rom_addr_i = 32'h4;
    wait_ready(10, t2, rd1);
    check("b2b_gap", 32'(t2 - t1), 32'd5);
    check("b2b_second_data", bus.rom_data_o, 32'h0020_0593);
    wait_ready(10, t3, rd2);
    check("repeat_gap", 32'(t3 - t2), 32'(HitGap));
    check("repeat_data", bus.rom_data_o, 32'h0020_0593);
    check("repeat_mem_rd", 32'(rd2), 32'(HitRd));
    bus.rom_ce_i = 1'b0;
    @(negedge clk);
    check("b2b_ready_clear", 32'(bus.rom_ready_o), 32'd0);
    $display("b2b gaps=%0d,%0d rd=%0d%0d%0d data=%08h", t2 - t1, t3 - t2, rd0, rd1, rd2,
             bus.rom_data_o);

    // Reset mid-fetch: outputs clear immediately, next request is a fresh miss.
    bus.rom_ce_i   = 1'b1;
    bus.rom_addr_i = 32'h104;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_data", bus.rom_data_o, 32'h0);
    check("mid_rst_ready", 32'(bus.rom_ready_o), 32'd0);
    check("mid_rst_mem_a", 32'(bus.mem_a_o), 32'd0);
    check("mid_rst_mem_rd", 32'(bus.mem_rd_o), 32'd0);
    $display("mid-fetch reset data=%08h mem_a=%05h", bus.rom_data_o, bus.mem_a_o);
    bus.rom_ce_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_fetch(32'h4, 17'h00004, 32'h0020_0593);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/inst_fetch_resp.md
# inst_fetch_resp

Instruction-fetch responder: the memory-side end of the core's `rom_ce_o` / `rom_addr_o` / `rom_data_i` fetch port. It accepts a word fetch request from the core and assembles the 32-bit instruction from a byte-wide synchronous memory using four sequential byte reads. It returns the word little-endian with a one-cycle ready pulse. It sits between the core top and the board's byte RAM, which has 1-cycle read latency.

## Interface

Parameters:
- MEM_AW, 17, byte-address width of the backing memory.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- rom_ce_i  input  1  fetch request from the core; level-sensitive.
- rom_addr_i  input  32  fetch byte address; bits [1:0] are ignored and the fetch is word-aligned.
- rom_data_o  output  32  assembled instruction; held stable until the next completion.
- rom_ready_o  output  1  one-cycle pulse: rom_data_o is valid for the current request.
- mem_a_o  output  MEM_AW  byte address to memory; registered.
- mem_rd_o  output  1  memory read strobe; registered.
- mem_din_i  input  8  memory read data; returns the byte addressed in the previous cycle.

## Operation

- States: IDLE, READ (cnt 0..3), DONE.
- Reset values (rst low, asynchronous): state=IDLE, cnt=0, rom_data_o=0, rom_ready_o=0, mem_a_o=0, mem_rd_o=0.
- IDLE or DONE with rom_ce_i=1:
  - Accept the request.
  - Latch base W = {rom_addr_i[MEM_AW-1:2], 2'b00}.
  - Drive mem_a_o=W, mem_rd_o=1, cnt=0, then go to READ.
- IDLE or DONE with rom_ce_i=0: go to (or stay in) IDLE, mem_rd_o=0.
- READ:
  - Each edge: mem_a_o = W+cnt+1, and assert mem_rd_o while cnt<3.
  - mem_din_i is captured into byte lane cnt of the shift/assembly register, i.e. byte k goes to rom_data_o[8k+7:8k].
  - After byte 3 is captured: rom_data_o is loaded, rom_ready_o=1, state goes to DONE.
- DONE: rom_ready_o high for exactly this cycle, then cleared at the next edge.
- Address arithmetic: W+k is computed modulo 2^MEM_AW. Upper address bits above MEM_AW are ignored.
- Abort: rom_ce_i=0 in READ abandons the fetch.
  - Next edge goes to IDLE, mem_rd_o=0, no ready.
  - rom_data_o keeps its old value.
- Restart: rom_addr_i word address differs from W while in READ and rom_ce_i=1.
  - Treat as a new acceptance: reload W, cnt=0, and stay in READ.
  - No ready is produced for the stale address.
- Memory bytes returning after an abort or restart are discarded.

## Timing

- Acceptance edge E0 puts address W on mem_a_o.
- Edges E1, E2, E3 issue W+1..W+3; the byte for W+k is captured at edge E(k+1).
- rom_ready_o and the final rom_data_o are registered at E4 and visible in the cycle E4–E5. Miss latency is 4 cycles after acceptance.
- Back-to-back: a new request seen in the DONE cycle is accepted at E5. Sustained throughput is one word per 5 cycles.
- mem_rd_o is high exactly during the 4 cycles in which mem_a_o carries W..W+3.
- Reset asserted mid-fetch clears everything immediately; the fetch is lost and no ready is produced.

## Configuration

- ROM_HIT_CACHE_EN defined:
  - Keeps a one-entry last-word cache holding a valid bit, a word-address tag and the data.
  - On acceptance, if valid and the tag matches: no memory access, mem_rd_o stays 0, rom_ready_o=1 at the next edge (1-cycle latency), rom_data_o = cached word.
  - Every completed miss fills the cache.
  - Reset clears the valid bit.
- ROM_HIT_CACHE_EN undefined: no cache storage; every request takes the 4-cycle miss path.

## Structure

- Shared defines file holds:
  - state encodings (IDLE/READ/DONE);
  - `InstAddrBus` and `RegBus` widths;
  - the byte-lane constant ByteWidth=8.
- Optional sub-module `rom_hit_cache` holds the tag/valid/data entry and lookup. It is instantiated only under ROM_HIT_CACHE_EN.

## Test plan

- Reset, then memory bytes 0x00..0x03 = 13,05,10,00. Request 0x0 held → mem_a_o 0,1,2,3 with mem_rd_o=1; ready pulse 4 cycles after accept; rom_data_o=0x00100513.
- Request 0x106 → fetch aligned to 0x104; MEM_AW=17 with request 0x1FFFC → mem_a_o sequence 1FFFC..1FFFF with no overflow outside range.
- rom_ce_i dropped at cnt=1 → no ready; rom_data_o unchanged; IDLE next edge.
- Address changed 0x8→0xC at cnt=2 → fetch restarts at 0xC; a single ready carries the word at 0xC.
- Back-to-back 0x0, 0x4 (ce held, address updated in the ready cycle) → ready pulses 5 cycles apart. With ROM_HIT_CACHE_EN, a repeat of 0x4 → ready next cycle, mem_rd_o=0.
- Reset pulsed mid-READ → all outputs 0 asynchronously; the next request behaves as a fresh miss (cache cleared).
